// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op_code encodings and response record for the ALU command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: OP_* op_code values driven on alu_op_code; alu_rsp_t is the {result, tag}
// response record at the default 32-bit result / 4-bit tag configuration.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int RSP_RESULT_W = 32;
  localparam int RSP_TAG_W    = 4;

  typedef struct packed {
    logic [RSP_RESULT_W-1:0] result;
    logic [RSP_TAG_W-1:0]    tag;
  } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// alu_rsp_fifo: synchronous first-word-fall-through FIFO holding tagged ALU responses.
// Latency: a push at edge N is visible on o_head_dat / !o_empty after edge N.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
// Ports: clk/rst (sync, active-high); i_push/i_push_dat write side; i_pop read side;
// o_head_dat oldest entry; o_count occupancy; o_full/o_empty status.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_push_dat,
  input  logic                   i_pop,
  output logic [W-1:0]           o_head_dat,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // A pop on empty is ignored; a push on full is allowed only when it is
  // paired with a pop, so the slot it needs is being freed at the same edge.
  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_count == '0);

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues tagged commands to an external combinational ALU and returns tagged results.
// Latency: command accepted at edge N -> ALU operands in cycle N+1 -> FIFO write at N+RESULT_LAT -> rsp_valid after that edge.
// Backpressure: a response slot is reserved per accepted command; cmd_ready drops when no slot is free.
// Ports: clk/rst (sync, active-high); cmd_* command stream; alu_* registered ALU drive, alu_result ALU return;
// rsp_* response stream; busy = work in flight or responses pending.
// Option macro ALU_CHAIN_EN: cmd_chain substitutes the last written result for operand A, stalling
// chain commands while any result is still in flight. Without it cmd_chain is ignored.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int RESULT_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             cmd_chain,
  output logic [1:0]       alu_op_code,
  output logic [WIDTH-1:0] alu_operand_a,
  output logic [WIDTH-1:0] alu_operand_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int CW = $clog2(RSP_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [CW-1:0]         r_credit;
  logic [CW-1:0]         r_inflight;
  logic [RESULT_LAT-1:0] r_pipe_vld;
  logic [TAG_W-1:0]      r_pipe_tag [RESULT_LAT];

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_wr;
  logic                  w_stall;
  logic [WIDTH-1:0]      w_op_a;
  rsp_t                  w_wr_dat;
  rsp_t                  w_head;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_full_unused;
  logic                  w_fifo_empty;

  assign w_wr     = r_pipe_vld[RESULT_LAT-1];
  assign w_pop    = rsp_valid && rsp_ready;
  assign cmd_ready = !rst && (r_credit != '0) && !w_stall;
  assign w_accept = cmd_valid && cmd_ready;

`ifdef ALU_CHAIN_EN
  logic [WIDTH-1:0] r_last_result;

  // With nothing in flight, r_last_result already holds the newest written result.
  assign w_stall = cmd_chain && (r_inflight != '0);
  assign w_op_a  = cmd_chain ? r_last_result : cmd_a;

  always_ff @(posedge clk) begin
    if (rst)       r_last_result <= '0;
    else if (w_wr) r_last_result <= alu_result;
  end
`else
  logic w_chain_unused;

  assign w_chain_unused = cmd_chain;
  assign w_stall        = 1'b0;
  assign w_op_a         = cmd_a;
`endif

  // Operand registers hold their last value while idle so the ALU inputs never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op_code   <= OP_ADD;
      alu_operand_a <= '0;
      alu_operand_b <= '0;
    end else if (w_accept) begin
      alu_op_code   <= cmd_op;
      alu_operand_a <= w_op_a;
      alu_operand_b <= cmd_b;
    end
  end

  // Credits count free response slots: reserved on accept, returned on pop.
  // In-flight count moves from pipe to FIFO on write without touching credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit   <= DEPTH_C;
      r_inflight <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
      case ({w_accept, w_wr})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Tag pipe aligned with the ALU: the last stage marks the cycle alu_result is sampled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_accept;
      for (int i = 1; i < RESULT_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_tag[0] <= cmd_tag;
    for (int i = 1; i < RESULT_LAT; i++) r_pipe_tag[i] <= r_pipe_tag[i-1];
  end

  assign w_wr_dat.result = alu_result;
  assign w_wr_dat.tag    = r_pipe_tag[RESULT_LAT-1];

  // Credits guarantee a write never meets a full FIFO, so the full flag is not needed here.
  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (WIDTH + TAG_W)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_wr),
    .i_push_dat (w_wr_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_fifo_count),
    .o_full     (w_fifo_full_unused),
    .o_empty    (w_fifo_empty)
  );

  assign rsp_valid  = !w_fifo_empty;
  assign rsp_result = w_head.result;
  assign rsp_tag    = w_head.tag;
  assign busy       = (r_inflight != '0) || (w_fifo_count != '0);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a scoreboard queue and response monitor.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Covers reset, issue timing, op_codes with wrap, backpressure, full push/pop, mid-flight reset, ALU_CHAIN_EN.
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [3:0]  cmd_tag;
  logic        cmd_chain;
  logic [1:0]  alu_op_code;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        busy;

  int       n_checks = 0;
  int       n_pass   = 0;
  int       both_cnt = 0;
  alu_rsp_t exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(
    .WIDTH(32), .TAG_W(4), .RSP_DEPTH(4), .RESULT_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .cmd_chain(cmd_chain),
    .alu_op_code(alu_op_code), .alu_operand_a(alu_operand_a),
    .alu_operand_b(alu_operand_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy)
  );

  // Combinational ALU standing in for the datapath.
  always_comb begin
    alu_result = '0;
    case (alu_op_code)
      2'b00: alu_result = alu_operand_a + alu_operand_b;
      2'b01: alu_result = alu_operand_a - alu_operand_b;
      2'b10: alu_result = alu_operand_a & alu_operand_b;
      2'b11: alu_result = alu_operand_a | alu_operand_b;
      default: alu_result = '0;
    endcase
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: every handshaken response is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && cmd_valid && cmd_ready && rsp_valid && rsp_ready) both_cnt++;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got tag %0h result %0h, none expected", rsp_tag, rsp_result);
      end else begin
        alu_rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_tag", {60'd0, rsp_tag}, {60'd0, e.tag});
        chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.result});
      end
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input logic chain);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_tag   = tag;
    cmd_chain = chain;
  endtask

  // Waits for the handshake, records the expectation, and returns 1 unit after the accepting edge.
  task automatic wait_accept(input bit push, input logic [31:0] exp_res);
    bit ok;
    alu_rsp_t e;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      if (push) begin
        e.result = exp_res;
        e.tag    = cmd_tag;
        exp_q.push_back(e);
      end
    end else begin
      n_checks++;
      $display("FAIL accept_timeout: tag %0h cmd_ready %0b, required 1", cmd_tag, cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_chain = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input bit push, input logic [31:0] exp_res);
    drive_cmd(op, a, b, tag, 1'b0);
    wait_accept(push, exp_res);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk({name, "_pending"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_busy"}, {63'd0, busy}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
    cmd_tag = '0; cmd_chain = 1'b0; rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_alu_a", {32'd0, alu_operand_a}, 0);
    chk("rst_cmd_ready_after", {63'd0, cmd_ready}, 1);
    @(posedge clk); #1;

    // Single add: operands in cycle N+1, response in cycle N+2
    send(OP_ADD, 32'd5, 32'd7, 4'd3, 1'b1, 32'd12);
    @(negedge clk);
    chk("issue_op", {62'd0, alu_op_code}, 0);
    chk("issue_a", {32'd0, alu_operand_a}, 5);
    chk("issue_b", {32'd0, alu_operand_b}, 7);
    chk("rsp_not_yet", {63'd0, rsp_valid}, 0);
    @(negedge clk);
    chk("rsp_at_n2", {63'd0, rsp_valid}, 1);
    drain("single");

    // Op_code and wrap vectors, back to back
    send(OP_SUB, 32'h0000_0000, 32'h0000_0001, 4'd1, 1'b1, 32'hFFFF_FFFF);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0002, 4'd2, 1'b1, 32'h0000_0001);
    send(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 4'd4, 1'b1, 32'h00F0_1234);
    send(OP_OR,  32'h1200_0000, 32'h0000_0034, 4'd5, 1'b1, 32'h1200_0034);
    send(OP_SUB, 32'd10, 32'd3, 4'd6, 1'b1, 32'd7);
`ifndef ALU_CHAIN_EN
    drive_cmd(OP_ADD, 32'd100, 32'd1, 4'd7, 1'b1);
    wait_accept(1'b1, 32'd101);
`endif
    drain("vectors");

    // Backpressure: only four slots
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(OP_ADD, i, 32'd100, 4'(i), 1'b1, 32'd100 + i);
    drive_cmd(OP_ADD, 32'd4, 32'd100, 4'd4, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_cmd_ready", {63'd0, cmd_ready}, 0);
      chk("bp_head_tag", {60'd0, rsp_tag}, 0);
    end
    chk("bp_rsp_valid", {63'd0, rsp_valid}, 1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_accept(1'b1, 32'd104);
    send(OP_ADD, 32'd5, 32'd100, 4'd5, 1'b1, 32'd105);
    drain("bp");

    // Full FIFO, then stream with pops: accept and pop share cycles
    rsp_ready = 1'b0;
    for (int i = 8; i < 12; i++) send(OP_OR, 32'h100 * i, 32'd1, 4'(i), 1'b1, (32'h100 * i) | 32'd1);
    repeat (3) @(posedge clk);
    #1;
    both_cnt = 0;
    rsp_ready = 1'b1;
    for (int i = 12; i < 16; i++) send(OP_SUB, 32'd1000, i, 4'(i), 1'b1, 32'd1000 - i);
    drain("full");
    chk("simul_push_pop_cycles", both_cnt, 4);

`ifdef ALU_CHAIN_EN
    // Chain hazard: second command waits for the first result, then uses it as A
    send(OP_ADD, 32'd2, 32'd3, 4'd0, 1'b1, 32'd5);
    drive_cmd(OP_ADD, 32'd999, 32'd10, 4'd1, 1'b1);
    @(negedge clk);
    chk("chain_stall", {63'd0, cmd_ready}, 0);
    wait_accept(1'b1, 32'd15);
    drain("chain");
`endif

    // Reset with two commands in flight: both are discarded
    rsp_ready = 1'b0;
    send(OP_SUB, 32'd50, 32'd1, 4'd1, 1'b0, 32'd0);
    send(OP_SUB, 32'd60, 32'd2, 4'd2, 1'b0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_cmd_ready", {63'd0, cmd_ready}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 0);
    chk("midrst_op", {62'd0, alu_op_code}, 0);
    chk("midrst_a", {32'd0, alu_operand_a}, 0);
    chk("midrst_b", {32'd0, alu_operand_b}, 0);
    chk("midrst_cmd_ready_after", {63'd0, cmd_ready}, 1);
    seen = rsp_valid;
    repeat (3) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("midrst_no_rsp", {63'd0, seen}, 0);
    @(posedge clk); #1;
    send(OP_OR, 32'd1, 32'd2, 4'd9, 1'b1, 32'd3);
    drain("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
